// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: core data port, SPI loader port and memory port bundled for the arbiter
interface spi_bus_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      i_core_addr;
    logic [31:0]      i_core_wr_data;
    logic [3:0]       i_core_size;
    logic             i_core_read;
    logic             i_core_write;
    logic [31:0]      o_core_rd_data;
    logic             o_core_stall;
    logic             i_req_spi;
    logic             o_gnt_spi;
    logic [31:0]      i_spi_addr;
    logic [31:0]      i_spi_wr_data;
    logic [3:0]       i_spi_size;
    logic             i_spi_read;
    logic             i_spi_write;
    logic [31:0]      o_spi_rd_data;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_wr_data;
    logic [3:0]       o_mem_size;
    logic             o_mem_read;
    logic             o_mem_write;
    logic [31:0]      i_mem_rd_data;
    logic [CNT_W-1:0] o_spi_wr_count;

    modport slave (
        input  i_core_addr, i_core_wr_data, i_core_size, i_core_read, i_core_write,
        input  i_req_spi, i_spi_addr, i_spi_wr_data, i_spi_size, i_spi_read, i_spi_write,
        input  i_mem_rd_data,
        output o_core_rd_data, o_core_stall, o_gnt_spi, o_spi_rd_data,
        output o_mem_addr, o_mem_wr_data, o_mem_size, o_mem_read, o_mem_write,
        output o_spi_wr_count
    );

    modport master (
        output i_core_addr, i_core_wr_data, i_core_size, i_core_read, i_core_write,
        output i_req_spi, i_spi_addr, i_spi_wr_data, i_spi_size, i_spi_read, i_spi_write,
        output i_mem_rd_data,
        input  o_core_rd_data, o_core_stall, o_gnt_spi, o_spi_rd_data,
        input  o_mem_addr, o_mem_wr_data, o_mem_size, o_mem_read, o_mem_write,
        input  o_spi_wr_count
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares the memory port between the core and the SPI loader, loader always granted next cycle
module spi_bus_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    spi_bus_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic             gnt;
    logic             rd_owner;
    logic             rd_valid;
    logic [CNT_W-1:0] wr_count;

    assign gnt                = (state == GRANT);
    assign bus.o_gnt_spi      = gnt;
    assign bus.o_spi_wr_count = wr_count;

    // Each request pulse buys exactly the following cycle on the bus; back-to-back pulses chain grants
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= bus.i_req_spi ? GRANT : IDLE;
    end

    // Memory mux and read-data steering; the loader owns the port only during its grant cycle
    always_comb begin
        bus.o_mem_addr     = gnt ? bus.i_spi_addr    : bus.i_core_addr;
        bus.o_mem_wr_data  = gnt ? bus.i_spi_wr_data : bus.i_core_wr_data;
        bus.o_mem_size     = gnt ? bus.i_spi_size    : bus.i_core_size;
        bus.o_mem_read     = gnt ? bus.i_spi_read    : bus.i_core_read;
        bus.o_mem_write    = gnt ? bus.i_spi_write   : bus.i_core_write;
        bus.o_core_stall   = gnt & (bus.i_core_read | bus.i_core_write);
        bus.o_core_rd_data = (rd_valid & ~rd_owner) ? bus.i_mem_rd_data : 32'h0;
        bus.o_spi_rd_data  = (rd_valid &  rd_owner) ? bus.i_mem_rd_data : 32'h0;
    end

    // Tag each read with its issuer so the next-cycle memory data returns to the right master; count SPI commits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            wr_count <= '0;
        end else begin
            rd_valid <= bus.o_mem_read;
            if (bus.o_mem_read)            rd_owner <= gnt;
            if (gnt & bus.i_spi_write)     wr_count <= wr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_spi_bus_arbiter;
    typedef struct packed {
        logic [7:0]  id;
        logic        req, cr, cw, sr, sw;
        logic [31:0] ca, cd, sa, sd;
        logic [3:0]  cs, ss;
        logic        gnt, stall, mr, mw;
        logic [31:0] ma, md, crd, srd;
        logic [3:0]  ms;
        logic [1:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;
    int   vid = 0;
    vec_t v;
    vec_t e;
    vec_t exp_q[$];
    logic [31:0] mem [0:1023] = '{default: 32'h0};

    spi_bus_arbiter_if #(.CNT_W(2)) bus ();

    spi_bus_arbiter #(.CNT_W(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: byte-enabled writes, read data one cycle later, junk when not reading
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.o_mem_write && bus.o_mem_size[b])
                mem[bus.o_mem_addr[11:2]][8*b +: 8] <= bus.o_mem_wr_data[8*b +: 8];
        bus.i_mem_rd_data <= bus.o_mem_read ? mem[bus.o_mem_addr[11:2]] : 32'hBAD0BAD0;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s (vec %0d): got 0x%h, expected 0x%h", n, cur, a, x);
        end
    endtask

    // Monitor: every driven cycle carries an expected record; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur = int'(e.id);
            chk("gnt",      32'(bus.o_gnt_spi),      32'(e.gnt));
            chk("stall",    32'(bus.o_core_stall),   32'(e.stall));
            chk("mem_addr", bus.o_mem_addr,          e.ma);
            chk("mem_data", bus.o_mem_wr_data,       e.md);
            chk("mem_size", 32'(bus.o_mem_size),     32'(e.ms));
            chk("mem_rd",   32'(bus.o_mem_read),     32'(e.mr));
            chk("mem_wr",   32'(bus.o_mem_write),    32'(e.mw));
            chk("core_rd",  bus.o_core_rd_data,      e.crd);
            chk("spi_rd",   bus.o_spi_rd_data,       e.srd);
            chk("wr_count", 32'(bus.o_spi_wr_count), 32'(e.cnt));
        end
    end

    task automatic clr();
        v = '0;
    endtask

    task automatic core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        v.cr = r; v.cw = w; v.ca = a; v.cd = d; v.cs = s;
    endtask

    task automatic spi(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        v.sr = r; v.sw = w; v.sa = a; v.sd = d; v.ss = s;
    endtask

    task automatic exm(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        v.mr = r; v.mw = w; v.ma = a; v.md = d; v.ms = s;
    endtask

    task automatic ex(input logic g, input logic st, input logic [31:0] crd, input logic [31:0] srd, input logic [1:0] c);
        v.gnt = g; v.stall = st; v.crd = crd; v.srd = srd; v.cnt = c;
    endtask

    task automatic apply();
        bus.i_req_spi      = v.req;
        bus.i_core_read    = v.cr;
        bus.i_core_write   = v.cw;
        bus.i_core_addr    = v.ca;
        bus.i_core_wr_data = v.cd;
        bus.i_core_size    = v.cs;
        bus.i_spi_read     = v.sr;
        bus.i_spi_write    = v.sw;
        bus.i_spi_addr     = v.sa;
        bus.i_spi_wr_data  = v.sd;
        bus.i_spi_size     = v.ss;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        vid++;
        v.id = 8'(vid);
        apply();
        exp_q.push_back(v);
    endtask

    initial begin
        // Reset state, with a core write visible on the memory port during reset
        clr(); core(0, 1, 32'h55, 32'h1, 4'hF); apply();
        #2;
        cur = 0;
        chk("rst_gnt",      32'(bus.o_gnt_spi),      32'h0);
        chk("rst_stall",    32'(bus.o_core_stall),   32'h0);
        chk("rst_count",    32'(bus.o_spi_wr_count), 32'h0);
        chk("rst_core_rd",  bus.o_core_rd_data,      32'h0);
        chk("rst_spi_rd",   bus.o_spi_rd_data,       32'h0);
        chk("rst_mem_addr", bus.o_mem_addr,          32'h55);
        chk("rst_mem_wr",   32'(bus.o_mem_write),    32'h1);
        clr(); apply();
        @(posedge clk); #3; rst_n = 1'b1;

        // Idle core write then read back
        clr(); core(0, 1, 32'h100, 32'hDEADBEEF, 4'hF); exm(0, 1, 32'h100, 32'hDEADBEEF, 4'hF); ex(0, 0, 0, 0, 0); go();
        clr(); core(1, 0, 32'h100, 0, 4'hF); exm(1, 0, 32'h100, 0, 4'hF); ex(0, 0, 0, 0, 0); go();
        clr(); ex(0, 0, 32'hDEADBEEF, 0, 0); go();
        // SPI write: request, then grant cycle
        clr(); v.req = 1; ex(0, 0, 0, 0, 0); go();
        clr(); spi(0, 1, 32'h200, 32'h12345678, 4'h3); exm(0, 1, 32'h200, 32'h12345678, 4'h3); ex(1, 0, 0, 0, 0); go();
        clr(); ex(0, 0, 0, 0, 1); go();
        // Contention: core write held across the grant
        clr(); v.req = 1; core(0, 1, 32'h300, 32'hAAAA5555, 4'hF); exm(0, 1, 32'h300, 32'hAAAA5555, 4'hF); ex(0, 0, 0, 0, 1); go();
        clr(); core(0, 1, 32'h300, 32'hAAAA5555, 4'hF); spi(0, 1, 32'h204, 32'hCAFEF00D, 4'hF);
        exm(0, 1, 32'h204, 32'hCAFEF00D, 4'hF); ex(1, 1, 0, 0, 1); go();
        clr(); core(0, 1, 32'h300, 32'hAAAA5555, 4'hF); exm(0, 1, 32'h300, 32'hAAAA5555, 4'hF); ex(0, 0, 0, 0, 2); go();
        // Read ownership split
        clr(); v.req = 1; core(1, 0, 32'h100, 0, 4'hF); exm(1, 0, 32'h100, 0, 4'hF); ex(0, 0, 0, 0, 2); go();
        clr(); spi(1, 0, 32'h200, 0, 4'hF); exm(1, 0, 32'h200, 0, 4'hF); ex(1, 0, 32'hDEADBEEF, 0, 2); go();
        clr(); ex(0, 0, 0, 32'h00005678, 2); go();
        // SPI strobes without a grant never reach memory
        clr(); spi(1, 1, 32'h208, 32'h11111111, 4'hF); ex(0, 0, 0, 0, 2); go();
        clr(); ex(0, 0, 0, 0, 2); go();
        // Core read stalled by an idle grant, then re-presented
        clr(); v.req = 1; ex(0, 0, 0, 0, 2); go();
        clr(); core(1, 0, 32'h300, 0, 4'hF); ex(1, 1, 0, 0, 2); go();
        clr(); core(1, 0, 32'h300, 0, 4'hF); exm(1, 0, 32'h300, 0, 4'hF); ex(0, 0, 0, 0, 2); go();
        clr(); ex(0, 0, 32'hAAAA5555, 0, 2); go();
        // Asynchronous reset in the middle of a grant
        clr(); v.req = 1; ex(0, 0, 0, 0, 2); go();
        clr(); core(0, 1, 32'h400, 32'h77, 4'hF); spi(0, 1, 32'h220, 32'h55, 4'hF);
        exm(0, 1, 32'h220, 32'h55, 4'hF); ex(1, 1, 0, 0, 2); go();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        cur = 100;
        chk("arst_gnt",      32'(bus.o_gnt_spi),      32'h0);
        chk("arst_stall",    32'(bus.o_core_stall),   32'h0);
        chk("arst_count",    32'(bus.o_spi_wr_count), 32'h0);
        chk("arst_mem_addr", bus.o_mem_addr,          32'h400);
        chk("arst_mem_data", bus.o_mem_wr_data,       32'h77);
        clr(); apply();
        @(posedge clk); #3; rst_n = 1'b1;
        // Back-to-back grants and counter wrap (CNT_W=2)
        clr(); v.req = 1; ex(0, 0, 0, 0, 0); go();
        clr(); v.req = 1; spi(0, 1, 32'h210, 32'h1, 4'hF); exm(0, 1, 32'h210, 32'h1, 4'hF); ex(1, 0, 0, 0, 0); go();
        clr(); v.req = 1; spi(0, 1, 32'h214, 32'h2, 4'hF); exm(0, 1, 32'h214, 32'h2, 4'hF); ex(1, 0, 0, 0, 1); go();
        clr(); v.req = 1; spi(0, 1, 32'h218, 32'h3, 4'hF); exm(0, 1, 32'h218, 32'h3, 4'hF); ex(1, 0, 0, 0, 2); go();
        clr(); v.req = 1; spi(0, 1, 32'h21C, 32'h4, 4'hF); exm(0, 1, 32'h21C, 32'h4, 4'hF); ex(1, 0, 0, 0, 3); go();
        clr(); spi(0, 1, 32'h220, 32'h5, 4'hF); exm(0, 1, 32'h220, 32'h5, 4'hF); ex(1, 0, 0, 0, 0); go();
        clr(); ex(0, 0, 0, 0, 1); go();
        clr(); spi(0, 1, 32'h224, 32'h6, 4'hF); ex(0, 0, 0, 0, 1); go();
        clr(); ex(0, 0, 0, 0, 1); go();
        @(negedge clk); #1;
        cur = 200;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Arbitrates the single memory/bus slave port between the CPU core data port and the SPI loader master, which issues one-cycle request/grant word writes.
- Sits directly downstream of the SPI loader and upstream of the data memory.
- Guarantees the loader a grant exactly one cycle after its request, stalling the core during that cycle.
- Routes synchronous-memory read data back to whichever master issued the read.

Parameters:
- CNT_W, 16, width of the committed-SPI-write counter o_spi_wr_count.

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_core_addr  input  32  core byte address
- i_core_wr_data  input  32  core write data
- i_core_size  input  4  core byte enables
- i_core_read  input  1  core read strobe
- i_core_write  input  1  core write strobe
- o_core_rd_data  output  32  read data returned to core
- o_core_stall  output  1  core must hold its request this cycle
- i_req_spi  input  1  SPI loader request, one-cycle pulse
- o_gnt_spi  output  1  grant to SPI loader (registered)
- i_spi_addr  input  32  SPI byte address (valid while granted)
- i_spi_wr_data  input  32  SPI write data
- i_spi_size  input  4  SPI byte enables
- i_spi_read  input  1  SPI read strobe
- i_spi_write  input  1  SPI write strobe
- o_spi_rd_data  output  32  read data returned to SPI
- o_mem_addr  output  32  memory address
- o_mem_wr_data  output  32  memory write data
- o_mem_size  output  4  memory byte enables
- o_mem_read  output  1  memory read strobe
- o_mem_write  output  1  memory write strobe
- i_mem_rd_data  input  32  memory read data, valid 1 cycle after o_mem_read
- o_spi_wr_count  output  CNT_W  number of committed SPI writes

Behaviour:
- FSM states: IDLE, GRANT.
  - IDLE -> GRANT when i_req_spi=1; otherwise stay in IDLE.
  - GRANT -> GRANT when i_req_spi=1 (back-to-back requests); otherwise GRANT -> IDLE.
- o_gnt_spi = (state==GRANT). It is decoded from a register, so it rises exactly one cycle after i_req_spi and lasts one cycle per request.
- Memory mux is combinational:
  - In GRANT: o_mem_* = i_spi_* (read/write strobes gated by grant).
  - In IDLE: o_mem_* = i_core_*.
- o_core_stall = (state==GRANT) & (i_core_read | i_core_write). The core's access in the request cycle itself proceeds unstalled.
- Read owner:
  - Register rd_owner captures 1 (SPI) or 0 (core) in any cycle where o_mem_read=1.
  - rd_valid is a register set to o_mem_read.
- Read data routing in the following cycle:
  - o_core_rd_data = i_mem_rd_data when rd_valid & ~rd_owner, else 0.
  - o_spi_rd_data = i_mem_rd_data when rd_valid & rd_owner, else 0.
  - A core read issued in the cycle before GRANT still returns to the core during GRANT.
- o_spi_wr_count increments by 1 on every cycle with GRANT & i_spi_write. It wraps modulo 2^CNT_W without saturating.
- SPI strobes outside GRANT are ignored and never reach memory.
- Reset (asynchronous, any time, including mid-GRANT):
  - state=IDLE, o_gnt_spi=0, rd_owner=0, rd_valid=0, o_spi_wr_count=0.
  - Combinational outputs follow from this: o_core_stall=0, rd data=0, o_mem_* = core inputs.
- Simultaneous core and SPI writes in GRANT: SPI wins and the core is stalled. The core write is not lost; it re-presents the write next cycle.

Test Plan:
- Idle core traffic: core write addr 0x100, data 0xDEADBEEF, size 4'hF; core read 0x100 next cycle -> o_mem_write same cycle; o_core_rd_data=0xDEADBEEF one cycle after read; o_core_stall never 1.
- SPI write: i_req_spi pulse at cycle N -> o_gnt_spi=1 only at N+1. At N+1 with i_spi_addr=0x200, data 0x12345678, write=1 -> o_mem_addr=0x200, o_mem_write=1, o_spi_wr_count=1 at N+2.
- Contention: core write 0x300 held continuously, SPI req at N -> core write reaches memory at N; o_core_stall=1 at N+1 with SPI on bus; core write appears again at N+2.
- Read-ownership split: core read 0x100 at N, SPI req at N, SPI read 0x200 at N+1 -> o_core_rd_data = mem[0x100] at N+1, o_spi_rd_data = mem[0x200] at N+2, other output 0.
- Back-to-back requests: i_req_spi high N and N+1 -> o_gnt_spi high N+1 and N+2. With CNT_W=2 and 5 granted writes, o_spi_wr_count wraps to 1.
- Reset in GRANT: assert i_rst_n=0 while o_gnt_spi=1 -> o_gnt_spi, o_core_stall and o_spi_wr_count drop to 0 immediately, without waiting for a clock edge.
